servo_array_ctrl: RTL and testbench
===================================

# servo_array_ctrl

Parametrised multi-channel hobby-servo controller for the robot arm/pan-tilt, the successor to the fixed three-servo engine top. It holds an independent target angle per channel, fed from debounced front-panel keys or a host write port. It slews each channel's output angle toward its target at a bounded rate and generates one glitch-free 50 Hz-class PWM per channel from a shared period counter.

## Interface
- CH, 3: number of servo channels (1..16)
- CLK_HZ, 50_000_000: clock frequency in Hz
- PERIOD_US, 20000: PWM period in µs
- MIN_US, 500: pulse width at 0°, in µs
- MAX_US, 2500: pulse width at 180°, in µs
- STEP_DEG, 10: target increment per key_inc press (1..180)
- INIT_ANGLE, 0: reset value of every target and current angle (0..180)
- DEB_CYC, 1_000_000: key debounce filter length in cycles (≥1)
- SLEW_CYC, 250_000: cycles per 1° of slew; 0 = no slew limiting

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- key_inc  in  1  raw, asynchronous key, active-high: step the selected channel
- key_sel  in  1  raw, asynchronous key, active-high: select the next channel
- wr_en  in  1  host write strobe, one cycle per write
- wr_ch  in  $clog2(CH) (min 1)  host channel index
- wr_angle  in  8  host target angle in degrees
- sel_ch  out  $clog2(CH) (min 1)  channel currently addressed by key_inc
- busy  out  CH  bit i set while current angle ≠ target angle on channel i
- pwm  out  CH  servo PWM outputs, registered

## Operation
- Derived constants, integer and truncated: PERIOD_CYC = PERIOD_US·CLK_HZ/1e6; MIN_CYC = MIN_US·CLK_HZ/1e6; CYC_PER_DEG = (MAX_US−MIN_US)·CLK_HZ/1e6/180. Pulse width = MIN_CYC + angle·CYC_PER_DEG. No runtime divider.
- Key path, per key: 2-flop synchroniser, then a filter counter.
  - The counter increments while the synchronised value ≠ the stable value and clears otherwise.
  - On reaching DEB_CYC, the stable value takes the synchronised value.
  - A stable 0→1 transition produces a one-cycle press event. Release generates nothing.
- key_sel press: sel_ch ← sel_ch+1, wrapping CH−1 → 0.
- key_inc press: target[sel_ch] ← target + STEP_DEG, or 0 if that sum exceeds 180. Do the arithmetic in 9 bits; 180 is reachable.
- Host write: wr_angle > 180 clamps to 180. A write with wr_ch ≥ CH is ignored.
- Simultaneous wr_en and key_inc press on the same channel: the write wins and the key event is dropped. Different channels: both apply.
- Simultaneous key_sel and key_inc presses: key_inc uses the old sel_ch.
- Slew:
  - A shared tick fires every SLEW_CYC cycles.
  - On each tick, every channel with cur ≠ target moves cur one degree toward the target.
  - SLEW_CYC = 0: cur follows target on the next cycle.
  - A target change mid-slew redirects from the present cur; there is no restart.
- PWM:
  - A shared counter runs 0..PERIOD_CYC−1 and wraps.
  - When the counter = 0, each channel latches width[i] from cur[i]. A mid-period cur change never alters the current pulse.
  - pwm[i] ← (cnt < width[i]), registered.

## Timing
- Reset (asynchronous assert), all outputs: pwm = 0, busy = 0, sel_ch = 0.
- Reset, internal state: targets and cur = INIT_ANGLE; width = MIN_CYC + INIT_ANGLE·CYC_PER_DEG; counters, synchronisers, stable values and slew tick = 0.
- The first PWM rising edge is 1 cycle after rst_n deassertion.
- Key latency: a raw edge held steady reaches target/sel_ch DEB_CYC+3 cycles later (2 sync + DEB_CYC filter + 1 event).
- A bounce shorter than DEB_CYC cycles produces no event.
- Host write: target updates on the cycle after wr_en. busy rises in that same cycle if target ≠ cur.
- busy clears in the cycle cur reaches target.
- A new angle appears on pwm at the next period start after cur changes, i.e. within PERIOD_CYC+1 cycles.
- Reset asserted mid-pulse forces pwm low immediately; a key press pending in the filter is discarded.

## Test plan
Bench parameters: CLK_HZ=1_000_000, CH=3, DEB_CYC=4, PERIOD_US=20000, MIN_US=500, MAX_US=2500, so CYC_PER_DEG = 11.

1. Reset release with INIT_ANGLE=0 → every pwm high exactly 500 cycles per 20000-cycle period; sel_ch=0; busy=0.
2. SLEW_CYC=0; write ch1 = 90 → from the next period start, pwm[1] high 1490 cycles; ch0 and ch2 unchanged. Write ch1 = 200 → clamps to 180, pulse 2480 cycles. Write wr_ch=3 → no change on any channel.
3. key_inc with a 2-cycle glitch → no change. Hold key_inc 10 cycles → target[0]=10 exactly 7 cycles after the edge. 19 clean presses → targets 10…180 then 0.
4. key_sel ×3 clean presses → sel_ch 1, 2, 0. A key_inc press after the first key_sel updates ch1 only.
5. SLEW_CYC=100; write ch2 = 30 from 0 → busy[2]=1 for 3000±100 cycles and cur rises 1°/tick. Write 10 mid-slew at cur=20 → reverses, busy clears at 10.
6. Same-cycle wr_en (ch0 = 45) and key_inc press with sel_ch=0 → target[0]=45. Assert rst_n low mid-pulse → pwm=0 asynchronously and all state returns to reset values.

Source files
------------

// File: rtl/servo_array_ctrl.sv
// Multi-channel hobby-servo controller: debounced keys or a host port set per-channel targets,
// outputs slew toward them at a bounded rate, and one shared period counter drives all PWMs.
`timescale 1ns/1ps
module servo_array_ctrl #(
    parameter int CH         = 3,
    parameter int CLK_HZ     = 50_000_000,
    parameter int PERIOD_US  = 20000,
    parameter int MIN_US     = 500,
    parameter int MAX_US     = 2500,
    parameter int STEP_DEG   = 10,
    parameter int INIT_ANGLE = 0,
    parameter int DEB_CYC    = 1_000_000,
    parameter int SLEW_CYC   = 250_000,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          key_inc,
    input  logic          key_sel,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [7:0]    wr_angle,
    output logic [CW-1:0] sel_ch,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] pwm
);
    localparam int PERIOD_CYC  = int'(longint'(PERIOD_US) * CLK_HZ / 1_000_000);
    localparam int MIN_CYC     = int'(longint'(MIN_US) * CLK_HZ / 1_000_000);
    localparam int CYC_PER_DEG = int'(longint'(MAX_US - MIN_US) * CLK_HZ / 1_000_000 / 180);
    localparam int MAX_CYC     = MIN_CYC + 180 * CYC_PER_DEG;
    localparam int WW          = $clog2(((PERIOD_CYC > MAX_CYC) ? PERIOD_CYC : MAX_CYC) + 1);
    localparam int DW          = $clog2(DEB_CYC + 1);
    localparam int SW          = (SLEW_CYC > 1) ? $clog2(SLEW_CYC) : 1;
    localparam int SLEW_LAST   = (SLEW_CYC > 0) ? SLEW_CYC - 1 : 0;
    localparam logic [7:0] INIT_A = 8'(INIT_ANGLE);

    function automatic logic [7:0] sat_angle(input logic [7:0] a);
        return (a > 8'd180) ? 8'd180 : a;
    endfunction

    // 9-bit sum so that 180 is reachable and anything beyond wraps to 0
    function automatic logic [7:0] step_angle(input logic [7:0] a);
        logic [8:0] sum;
        sum = {1'b0, a} + 9'(STEP_DEG);
        return (sum > 9'd180) ? 8'd0 : sum[7:0];
    endfunction

    function automatic logic [WW-1:0] width_of(input logic [7:0] a);
        return WW'(MIN_CYC) + WW'(a) * WW'(CYC_PER_DEG);
    endfunction

    logic [1:0]    key_p0, key_p1, key_stable, key_press;
    logic [DW-1:0] deb_cnt [2];

    // Stage p0/p1: synchronisers; filter promotes a steady level and emits a press on 0->1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0     <= '0;
            key_p1     <= '0;
            key_stable <= '0;
            key_press  <= '0;
            for (int k = 0; k < 2; k++) deb_cnt[k] <= '0;
        end else begin
            key_p0 <= {key_sel, key_inc};
            key_p1 <= key_p0;
            for (int k = 0; k < 2; k++) begin
                key_press[k] <= 1'b0;
                if (key_p1[k] != key_stable[k]) begin
                    if (deb_cnt[k] == DW'(DEB_CYC - 1)) begin
                        key_stable[k] <= key_p1[k];
                        key_press[k]  <= key_p1[k];
                        deb_cnt[k]    <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + 1'b1;
                    end
                end else begin
                    deb_cnt[k] <= '0;
                end
            end
        end
    end

    logic [7:0]    tgt [CH];
    logic [7:0]    cur [CH];
    logic [SW-1:0] slew_cnt;
    logic          slew_tick;

    assign slew_tick = (SLEW_CYC == 0) || (slew_cnt == SW'(SLEW_LAST));

    // Target/current stage: host write beats a key step on the same channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_ch   <= '0;
            slew_cnt <= '0;
            for (int i = 0; i < CH; i++) begin
                tgt[i] <= INIT_A;
                cur[i] <= INIT_A;
            end
        end else begin
            slew_cnt <= slew_tick ? '0 : slew_cnt + 1'b1;
            if (key_press[1])
                sel_ch <= (sel_ch == CW'(CH - 1)) ? '0 : sel_ch + 1'b1;
            for (int i = 0; i < CH; i++) begin
                if (wr_en && wr_ch == CW'(i))
                    tgt[i] <= sat_angle(wr_angle);
                else if (key_press[0] && sel_ch == CW'(i))
                    tgt[i] <= step_angle(tgt[i]);
                if (SLEW_CYC == 0)
                    cur[i] <= tgt[i];
                else if (slew_tick && cur[i] != tgt[i])
                    cur[i] <= (cur[i] < tgt[i]) ? cur[i] + 8'd1 : cur[i] - 8'd1;
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < CH; i++) busy[i] = (cur[i] != tgt[i]);
    end

    logic [WW-1:0] pwm_cnt;
    logic [WW-1:0] width [CH];

    // PWM stage: widths latch only at period start so a running pulse is never cut short
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm     <= '0;
            for (int i = 0; i < CH; i++) width[i] <= width_of(INIT_A);
        end else begin
            pwm_cnt <= (pwm_cnt == WW'(PERIOD_CYC - 1)) ? '0 : pwm_cnt + 1'b1;
            for (int i = 0; i < CH; i++) begin
                if (pwm_cnt == '0) begin
                    width[i] <= width_of(cur[i]);
                    pwm[i]   <= (width_of(cur[i]) != '0);
                end else begin
                    pwm[i] <= (pwm_cnt < width[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_array_ctrl.sv
// Directed bench for servo_array_ctrl: one instance without slew limiting, one with SLEW_CYC=100.
`timescale 1ns/1ps
module tb_servo_array_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_inc, key_sel, wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_angle;
    logic [1:0] sel_ch;
    logic [2:0] busy, pwm;

    logic       s_key_inc, s_key_sel, s_wr_en;
    logic [1:0] s_wr_ch;
    logic [7:0] s_wr_angle;
    logic [1:0] s_sel_ch;
    logic [2:0] s_busy, s_pwm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    servo_array_ctrl #(.CH(3), .CLK_HZ(1_000_000), .PERIOD_US(20000), .MIN_US(500),
        .MAX_US(2500), .STEP_DEG(10), .INIT_ANGLE(0), .DEB_CYC(4), .SLEW_CYC(0)) dut (
        .clk(clk), .rst_n(rst_n), .key_inc(key_inc), .key_sel(key_sel), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_angle(wr_angle), .sel_ch(sel_ch), .busy(busy), .pwm(pwm));

    servo_array_ctrl #(.CH(3), .CLK_HZ(1_000_000), .PERIOD_US(20000), .MIN_US(500),
        .MAX_US(2500), .STEP_DEG(10), .INIT_ANGLE(0), .DEB_CYC(4), .SLEW_CYC(100)) dut_s (
        .clk(clk), .rst_n(rst_n), .key_inc(s_key_inc), .key_sel(s_key_sel), .wr_en(s_wr_en),
        .wr_ch(s_wr_ch), .wr_angle(s_wr_angle), .sel_ch(s_sel_ch), .busy(s_busy), .pwm(s_pwm));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit sel);
        if (sel) key_sel = 1'b1; else key_inc = 1'b1;
        step(10);
        key_sel = 1'b0;
        key_inc = 1'b0;
        step(10);
    endtask

    task automatic host_write(input logic [1:0] ch, input logic [7:0] ang);
        wr_en = 1'b1; wr_ch = ch; wr_angle = ang;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic measure(output int waited, output int w0, output int w1, output int w2);
        waited = 0; w0 = 0; w1 = 0; w2 = 0;
        while (pwm[0] !== 1'b0 && waited < 25000) begin step(1); waited++; end
        while (pwm[0] !== 1'b1 && waited < 25000) begin step(1); waited++; end
        check("pwm_period_start_seen", waited < 25000, 1);
        for (int c = 0; c < 2600; c++) begin
            if (pwm[0]) w0++;
            if (pwm[1]) w1++;
            if (pwm[2]) w2++;
            step(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wt, w0, w1, w2, exp0, guard;
        int b1, n1, bad, gap_bad, last_t, t, dur2, redir;
        logic [7:0] prev1, c1;

        rst_n = 1'b0; key_inc = 1'b0; key_sel = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_angle = '0;
        s_key_inc = 1'b0; s_key_sel = 1'b0; s_wr_en = 1'b0; s_wr_ch = '0; s_wr_angle = '0;
        step(3);
        check("rst_pwm", pwm, 0);
        check("rst_busy", busy, 0);
        check("rst_sel", sel_ch, 0);
        check("rst_s_pwm", s_pwm, 0);
        rst_n = 1'b1;

        // reset release: first rising edge one cycle later, 500-cycle pulses
        measure(wt, w0, w1, w2);
        check("first_rise_latency", wt, 1);
        check("init_w0", w0, 500);
        check("init_w1", w1, 500);
        check("init_w2", w2, 500);

        // host writes without slew limiting
        host_write(2'd1, 8'd90);
        check("wr90_busy_same_cycle", busy, 3'b010);
        check("wr90_tgt", dut.tgt[1], 90);
        step(1);
        check("wr90_busy_clear", busy, 0);
        measure(wt, w0, w1, w2);
        check("wr90_w0", w0, 500);
        check("wr90_w1", w1, 1490);
        check("wr90_w2", w2, 500);
        host_write(2'd1, 8'd200);
        check("wr200_clamp", dut.tgt[1], 180);
        measure(wt, w0, w1, w2);
        check("wr180_w1", w1, 2480);
        check("wr180_w0", w0, 500);
        host_write(2'd3, 8'd50);
        step(1);
        check("wr_oob_t0", dut.tgt[0], 0);
        check("wr_oob_t1", dut.tgt[1], 180);
        check("wr_oob_t2", dut.tgt[2], 0);

        // key_inc: glitch rejected, latency of DEB_CYC+3, wrap past 180
        key_inc = 1'b1; step(2); key_inc = 1'b0; step(20);
        check("glitch_tgt0", dut.tgt[0], 0);
        check("glitch_busy", busy, 0);
        key_inc = 1'b1;
        step(6);
        check("inc_before_latency", dut.tgt[0], 0);
        step(1);
        check("inc_at_latency", dut.tgt[0], 10);
        check("inc_busy", busy, 3'b001);
        step(3); key_inc = 1'b0; step(12);
        exp0 = 10;
        for (int p = 0; p < 18; p++) begin
            press(1'b0);
            exp0 = (exp0 + 10 > 180) ? 0 : exp0 + 10;
            check("inc_seq_tgt0", dut.tgt[0], exp0);
        end

        // key_sel walks channels; key_inc follows the selection
        press(1'b1);
        check("sel_1", sel_ch, 1);
        press(1'b0);
        check("inc_ch1_wrap", dut.tgt[1], 0);
        check("inc_ch1_t0", dut.tgt[0], 0);
        press(1'b1);
        check("sel_2", sel_ch, 2);
        press(1'b1);
        check("sel_0", sel_ch, 0);

        // slew: ch1 runs 0->30, ch2 redirected from 20 back to 10
        s_wr_en = 1'b1; s_wr_ch = 2'd1; s_wr_angle = 8'd30;
        step(1);
        check("slew_busy_rise", s_busy, 3'b010);
        s_wr_ch = 2'd2;
        step(1);
        s_wr_en = 1'b0;
        b1 = 2; n1 = 0; bad = 0; gap_bad = 0; last_t = -1; t = 0; dur2 = 0; redir = 0;
        prev1 = dut_s.cur[1];
        while (s_busy != 3'b000 && t < 5000) begin
            step(1);
            t++;
            s_wr_en = 1'b0;
            if (s_busy[1]) b1++;
            c1 = dut_s.cur[1];
            if (c1 != prev1) begin
                if (c1 != prev1 + 8'd1) bad++;
                if (last_t >= 0 && t - last_t != 100) gap_bad++;
                last_t = t;
                n1++;
                prev1 = c1;
            end
            if (redir != 0) begin
                if (s_busy[2]) dur2++;
            end else if (dut_s.cur[2] == 8'd20) begin
                redir = 1;
                s_wr_en = 1'b1; s_wr_ch = 2'd2; s_wr_angle = 8'd10;
            end
        end
        s_wr_en = 1'b0;
        check("slew_done_in_budget", t < 5000, 1);
        check("slew_busy1_span", (b1 >= 2890 && b1 <= 3010), 1);
        check("slew_steps1", n1, 30);
        check("slew_unit_steps", bad, 0);
        check("slew_tick_spacing", gap_bad, 0);
        check("slew_cur1", dut_s.cur[1], 30);
        check("slew_redirected", redir, 1);
        check("slew_cur2", dut_s.cur[2], 10);
        check("slew_back_span", (dur2 >= 950 && dur2 <= 1005), 1);

        // simultaneous write and key press
        key_inc = 1'b1; step(6);
        wr_en = 1'b1; wr_ch = 2'd0; wr_angle = 8'd45;
        step(1); wr_en = 1'b0;
        check("same_ch_write_wins", dut.tgt[0], 45);
        step(3); key_inc = 1'b0; step(12);
        check("same_ch_after", dut.tgt[0], 45);
        key_inc = 1'b1; step(6);
        wr_en = 1'b1; wr_ch = 2'd2; wr_angle = 8'd77;
        step(1); wr_en = 1'b0;
        check("diff_ch_key", dut.tgt[0], 55);
        check("diff_ch_write", dut.tgt[2], 77);
        step(3); key_inc = 1'b0; step(12);
        key_inc = 1'b1; key_sel = 1'b1;
        step(7);
        check("sel_inc_sel", sel_ch, 1);
        check("sel_inc_old_ch", dut.tgt[0], 65);
        check("sel_inc_ch1", dut.tgt[1], 0);
        step(3); key_inc = 1'b0; key_sel = 1'b0; step(12);

        // asynchronous reset mid-pulse with a key press still in the filter
        guard = 0;
        while (pwm[0] !== 1'b1 && guard < 21000) begin step(1); guard++; end
        check("pulse_seen_before_reset", guard < 21000, 1);
        key_inc = 1'b1;
        step(3);
        check("pwm_high_before_reset", pwm[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sel", sel_ch, 0);
        check("async_rst_t0", dut.tgt[0], 0);
        check("async_rst_t2", dut.tgt[2], 0);
        check("async_rst_cur0", dut.cur[0], 0);
        key_inc = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(20);
        check("pending_press_dropped", dut.tgt[0], 0);
        check("post_rst_sel", sel_ch, 0);
        check("post_rst_s_sel", s_sel_ch, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
